// File: rtl/cpu_seq_if.sv
// Sequencer bus: datapath status in, control strobes out.
// master = the side driving opcode/flags, slave = the sequencer.
interface cpu_seq_if #(
  parameter int OPCODE_W = 3
);
  logic                zero;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                go;
  logic                sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e;
  logic [2:0]          phase;
  logic                err;

  modport master (
    output zero, opcode, mem_ready, go,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, phase, err
  );
  modport slave (
    input  zero, opcode, mem_ready, go,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, phase, err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Eight-phase CPU control sequencer with RUN/HALTED top state and memory stalls.
// Optional wait-state timeout compiled in by CPU_SEQ_TIMEOUT_EN.
module cpu_sequencer #(
  parameter int OPCODE_W = 3,
  parameter int TO_LIMIT = 15
) (
  input  logic     clk,
  input  logic     rst,
  cpu_seq_if.slave bus
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_phase, w_phase_nxt;
  logic       w_alu, w_skz, w_jmp, w_sto, w_hlt, w_ill, w_stall, w_to;

  if (TO_LIMIT < 1 || TO_LIMIT > 255) begin : g_bad_to_limit
    $error("cpu_sequencer: TO_LIMIT must be 1..255");
  end

  // Codes wider than 3 bits with any upper bit set are illegal and halt.
  if (OPCODE_W > 3) begin : g_wide_op
    assign w_ill = |bus.opcode[OPCODE_W-1:3];
  end else begin : g_narrow_op
    assign w_ill = 1'b0;
  end

  assign w_alu = (bus.opcode >= OPCODE_W'(2)) && (bus.opcode <= OPCODE_W'(5));
  assign w_skz = (bus.opcode == OPCODE_W'(1)) && bus.zero;
  assign w_jmp = (bus.opcode == OPCODE_W'(7));
  assign w_sto = (bus.opcode == OPCODE_W'(6));
  assign w_hlt = (bus.opcode == '0) || w_ill;

  assign w_stall = (r_state == RUN) && !bus.mem_ready &&
                   ((r_phase == 3'd1) || (r_phase == 3'd5 && w_alu) ||
                    (r_phase == 3'd7 && w_sto));

`ifdef CPU_SEQ_TIMEOUT_EN
  logic [7:0] r_wcnt;
  logic       r_err;

  // Fires on the stalled cycle whose count would reach TO_LIMIT.
  assign w_to = w_stall && (r_wcnt == 8'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt <= 8'd0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= (w_stall && !w_to) ? r_wcnt + 8'd1 : 8'd0;
      if (w_to) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_to    = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_phase <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    if (r_state == HALTED) begin
      w_phase_nxt = 3'd0;
      if (bus.go) w_state_nxt = RUN;
    end else if (w_to || (r_phase == 3'd4 && w_hlt)) begin
      w_state_nxt = HALTED;
      w_phase_nxt = 3'd0;
    end else if (!w_stall) begin
      w_phase_nxt = r_phase + 3'd1;
    end
  end

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.halt   = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.data_e = 1'b0;
    if (r_state == HALTED) begin
      bus.halt = 1'b1;
    end else begin
      case (r_phase)
        3'd0: bus.sel = 1'b1;
        3'd1: begin bus.sel = 1'b1; bus.rd = 1'b1; end
        3'd2, 3'd3: begin bus.sel = 1'b1; bus.rd = 1'b1; bus.ld_ir = 1'b1; end
        3'd4: begin bus.inc_pc = 1'b1; bus.halt = w_hlt; end
        3'd5: bus.rd = w_alu;
        3'd6: begin
          bus.rd     = w_alu;
          bus.inc_pc = w_skz;
          bus.ld_pc  = w_jmp;
          bus.data_e = w_sto;
        end
        default: begin
          bus.rd     = w_alu;
          bus.ld_ac  = w_alu;
          bus.ld_pc  = w_jmp;
          bus.wr     = w_sto;
          bus.data_e = w_sto;
        end
      endcase
    end
  end

  assign bus.phase = r_phase;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized + directed bench for cpu_sequencer against a phase-table reference model.
module tb_cpu_sequencer;
  localparam int TO = 4;
`ifdef CPU_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_seq_if #(.OPCODE_W(3)) bus ();
  cpu_sequencer #(.OPCODE_W(3), .TO_LIMIT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0;
  bit m_halt;
  int m_ph, m_cnt;
  bit m_err;
  logic [8:0] last_strb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [8:0] strobes();
    return {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
            bus.ld_ac, bus.wr, bus.ld_pc, bus.data_e};
  endfunction

  // Expected strobes {sel,rd,ld_ir,halt,inc_pc,ld_ac,wr,ld_pc,data_e}.
  function automatic logic [8:0] exp_strb(bit h, int ph, int op, bit z);
    bit alu = (op >= 2 && op <= 5);
    bit skz = (op == 1) && z;
    bit jmp = (op == 7);
    bit sto = (op == 6);
    bit sel = 0, rd = 0, ldir = 0, hl = 0, inc = 0, ldac = 0, wr = 0, ldpc = 0, de = 0;
    if (h) hl = 1;
    else case (ph)
      0: sel = 1;
      1: begin sel = 1; rd = 1; end
      2, 3: begin sel = 1; rd = 1; ldir = 1; end
      4: begin inc = 1; hl = (op == 0); end
      5: rd = alu;
      6: begin rd = alu; inc = skz; ldpc = jmp; de = sto; end
      default: begin rd = alu; ldac = alu; ldpc = jmp; wr = sto; de = sto; end
    endcase
    return {sel, rd, ldir, hl, inc, ldac, wr, ldpc, de};
  endfunction

  task automatic model_step(input int op, input bit mr, input bit g);
    bit stall;
    if (m_halt) begin
      if (g) m_halt = 0;
      m_ph = 0; m_cnt = 0;
      return;
    end
    stall = !mr && (m_ph == 1 || (m_ph == 5 && op >= 2 && op <= 5) || (m_ph == 7 && op == 6));
    if (TO_EN && stall && m_cnt + 1 >= TO) begin
      m_err = 1; m_halt = 1; m_ph = 0; m_cnt = 0;
    end else if (m_ph == 4 && op == 0) begin
      m_halt = 1; m_ph = 0; m_cnt = 0;
    end else if (stall) begin
      m_cnt++;
    end else begin
      m_cnt = 0; m_ph = (m_ph + 1) % 8;
    end
  endtask

  // Called just after a falling edge; drives, checks, steps the model, waits one cycle.
  task automatic cyc(input int op, input bit mr, input bit z, input bit g);
    bus.opcode = 3'(op); bus.mem_ready = mr; bus.zero = z; bus.go = g;
    #1;
    last_strb = strobes();
    chk("strobes", 32'(last_strb), 32'(exp_strb(m_halt, m_ph, op, z)));
    chk("phase", 32'(bus.phase), 32'(m_ph));
    chk("err", 32'(bus.err), 32'(m_err));
    model_step(op, mr, g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_strobes", 32'(strobes()), 32'h100);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    m_halt = 0; m_ph = 0; m_cnt = 0; m_err = 0;
    @(posedge clk); #1;
    chk("rst_hold_phase", 32'(bus.phase), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_instr(input int op, input bit z, output int n_inc, output int n_ldpc);
    n_inc = 0; n_ldpc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(op, 1'b1, z, 1'b0);
      n_inc  += int'(last_strb[4]);
      n_ldpc += int'(last_strb[1]);
    end
  endtask

  initial begin
    int n, a, b;
    bus.opcode = 3'd5; bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.go = 1'b0;
    m_halt = 0; m_ph = 0; m_cnt = 0; m_err = 0;
    @(negedge clk);
    do_reset();

    // LDA, no stalls: full wrap, ld_ac once
    n = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(5, 1'b1, 1'b0, 1'b0);
      n += int'(last_strb[3]);
    end
    chk("lda_ld_ac_count", n, 1);

    // STO stalled 3 cycles in phase 7
    while (m_ph != 7) cyc(6, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(6, (i == 3), 1'b0, 1'b0);
      n += int'(last_strb[2] & last_strb[0]);
    end
    chk("sto_wr_cycles", n, 4);
    chk("sto_then_ph0", 32'(bus.phase), 32'd0);

    // HLT, idle in HALTED, resume
    while (!m_halt) cyc(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1);
    cyc(3, 1'b1, 1'b0, 1'b0);
    chk("resume_ph1", 32'(bus.phase), 32'd1);
    while (m_ph != 0) cyc(3, 1'b1, 1'b0, 1'b0);

    run_instr(1, 1'b1, a, b); chk("skz_z1_inc", a, 2);
    run_instr(1, 1'b0, a, b); chk("skz_z0_inc", a, 1);
    run_instr(7, 1'b0, a, b); chk("jmp_ld_pc", b, 2);

    // Phase-1 stall: timeout when enabled, unbounded otherwise
    cyc(5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(5, 1'b0, 1'b0, 1'b0);
    cyc(5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(5, 1'b1, 1'b0, 1'b0);
    chk("err_sticky", 32'(bus.err), 32'(TO_EN));
    do_reset();

    // Reset mid phase-5 stall
    for (int i = 0; i < 5; i++) cyc(2, 1'b1, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_ph5", 32'(bus.phase), 32'd5);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(int'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 3, opcode width (>=3); codes above 7 are illegal.
REQ-002 SHALL have parameter TO_LIMIT, default 15, wait-state cycles allowed before timeout (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports zero (input, 1, accumulator zero flag), opcode (input, OPCODE_W, IR opcode) and mem_ready (input, 1, memory completes current access this cycle).
REQ-006 SHALL have port go  input  1  resume pulse, leaves HALTED.
REQ-007 SHALL have outputs sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e (each 1 bit), with the same datapath meaning as the existing controller strobes.
REQ-008 SHALL have outputs phase (3 bits, current phase) and err (1 bit, sticky timeout flag).

Function
REQ-009 SHALL hold a registered top state RUN or HALTED and a registered 3-bit phase counter: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-010 In RUN, phase SHALL advance by 1 each cycle and wrap 7->0, except when stalled.
REQ-011 Stall: phase SHALL hold while mem_ready=0 in phase 1, in phase 5 when ALU_COND, and in phase 7 when STO_COND; strobes SHALL stay at that phase's values while held.
REQ-012 Conditions: ALU_COND = opcode in {ADD=2, AND=3, XOR=4, LDA=5}; SKZ_COND = opcode==1 and zero; JMP_COND = opcode==7; STO_COND = opcode==6; HLT_COND = opcode==0 or opcode>7.
REQ-013 Decode is combinational from (state, phase, conditions); every strobe not listed SHALL be 0.
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phases 2 and 3: sel, rd, ld_ir.
  - Phase 4: inc_pc, halt=HLT_COND.
  - Phase 5: rd=ALU_COND.
  - Phase 6: rd=ALU_COND, inc_pc=SKZ_COND, ld_pc=JMP_COND, data_e=STO_COND.
  - Phase 7: rd=ALU_COND, ld_ac=ALU_COND, ld_pc=JMP_COND, wr=STO_COND, data_e=STO_COND.
REQ-014 Phase 4 with HLT_COND SHALL transition RUN->HALTED at the next edge, with phase forced to 0.
REQ-015 In HALTED, halt=1, all other strobes 0, phase=0 and held; go=1 SHALL return to RUN at phase 0 on the next edge.
REQ-016 go SHALL be ignored in RUN.
REQ-017 zero and opcode SHALL be sampled combinationally each cycle; opcode changes mid-instruction take effect immediately.

Reset
REQ-018 rst=0 SHALL immediately force state RUN, phase 0, err 0 and timeout counter 0, independent of clk.
REQ-019 During and directly after reset, outputs SHALL be sel=1, all other strobes 0.
REQ-020 Reset asserted mid-stall or in HALTED SHALL abort the operation with no residual state.
REQ-021 The first rising edge after rst deasserts SHALL advance phase 0->1.

Configuration
REQ-022 Macro CPU_SEQ_TIMEOUT_EN, when defined, SHALL compile in an 8-bit wait counter.
  - The counter increments on each stalled cycle and clears on any non-stalled cycle.
  - When the counter reaches TO_LIMIT, err SHALL set (sticky until reset), the state SHALL go to HALTED with phase 0 at the next edge, and the counter SHALL clear.
REQ-023 Without CPU_SEQ_TIMEOUT_EN, there SHALL be no counter, err SHALL be constant 0, and stalls SHALL be unbounded.

Verification
REQ-024 Reset release, opcode=LDA, mem_ready=1 -> phase 0..7 in 8 cycles; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; wraps to phase 0.
REQ-025 opcode=STO, mem_ready=0 for 3 cycles in phase 7 -> wr=1 and data_e=1 held 4 cycles total; then phase 0.
REQ-026 opcode=HLT -> halt=1 in phase 4, then HALTED; 10 idle cycles hold phase 0 with halt=1; go pulse -> RUN, next cycle phase 1.
REQ-027 opcode=SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only; opcode=JMP -> ld_pc=1 in phases 6 and 7.
REQ-028 With CPU_SEQ_TIMEOUT_EN and TO_LIMIT=4, mem_ready held 0 in phase 1 -> err=1 after 4 stalled cycles, HALTED, err stays 1 after go, cleared only by rst=0.
REQ-029 rst=0 asserted mid-cycle during a phase-5 stall -> outputs become sel=1, others 0, before the next clk edge.
